// File: rtl/mem_access_unit_if.sv
// Pipeline-side request/response and data-memory bus of the load/store sequencer.
// The unit itself uses the slave modport; the pipeline/memory environment uses master.
interface mem_access_unit_if #(
  parameter int AW = 8
) ();
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          misalign_err;
  logic          mem_write;
  logic          mem_read;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, misalign_err,
    output mem_write, mem_read, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, misalign_err,
    input  mem_write, mem_read, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store sequencer over a word memory (RMW for sub-word stores); response 2-3 cycles after
// accept, req_ready low while busy. Define MISALIGN_TRAP_EN to trap misaligned half/word ops instead of truncating.
module mem_access_unit #(
  parameter int AW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_access_unit_if.slave bus
);
`ifdef MISALIGN_TRAP_EN
  typedef enum logic [2:0] {IDLE, RD, WR, RESP, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, RD, WR, RESP} state_t;
`endif

  state_t        state_q, state_d;
  logic [AW+1:0] addr_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic          we_q;
  logic [31:0]   wdata_q;
  logic          mem_read_q, mem_write_q, rsp_valid_q;
  logic [AW-1:0] mem_addr_q;
  logic [31:0]   mem_wdata_q, rsp_rdata_q;
  logic          accept;
  logic          unused_addr;

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] off,
                                           input logic [1:0] sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   r = {{24{b[7] & ~uns}}, b};
      2'b01:   r = {{16{h[15] & ~uns}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [15:0] d,
                                              input logic [1:0] off, input logic half);
    logic [31:0] r;
    r = w;
    if (half) r[{off[1], 4'b0000} +: 16] = d;
    else      r[{off, 3'b000} +: 8] = d[7:0];
    return r;
  endfunction

  assign accept        = bus.req_valid && (state_q == IDLE);
  assign unused_addr   = ^bus.req_addr[31:AW+2];
  assign bus.req_ready = (state_q == IDLE);

`ifdef MISALIGN_TRAP_EN
  logic misalign;
  logic misalign_q;
  assign misalign = (bus.req_size == 2'b01) ? bus.req_addr[0]
                                            : (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
  assign bus.misalign_err = misalign_q;
`else
  assign bus.misalign_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
`ifdef MISALIGN_TRAP_EN
          if (misalign) state_d = ERR;
          else
`endif
          if (bus.req_we && bus.req_size[1]) state_d = WR;
          else                               state_d = RD;
        end
      end
      RD:   state_d = we_q ? WR : RESP;
      WR:   state_d = RESP;
      RESP: state_d = IDLE;
`ifdef MISALIGN_TRAP_EN
      ERR:  state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= bus.req_addr[AW+1:0];
      size_q  <= bus.req_size;
      uns_q   <= bus.req_unsigned;
      we_q    <= bus.req_we;
      wdata_q <= bus.req_wdata;
    end
  end

  // Registered outputs trail the state by one cycle, so mem_rdata for a read is
  // consumed at the edge that leaves the state following RD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      mem_read_q  <= (state_q == RD);
      mem_write_q <= (state_q == WR);
      if (state_q == RD || state_q == WR) mem_addr_q <= addr_q[AW+1:2];
      if (state_q == WR)
        mem_wdata_q <= size_q[1] ? wdata_q
                                 : store_merge(bus.mem_rdata, wdata_q[15:0], addr_q[1:0], size_q[0]);
      rsp_rdata_q <= (state_q == RESP && !we_q) ? load_ext(bus.mem_rdata, addr_q[1:0], size_q, uns_q)
                                                : 32'h0;
`ifdef MISALIGN_TRAP_EN
      rsp_valid_q <= (state_q == RESP) || (state_q == ERR);
      misalign_q  <= (state_q == ERR);
`else
      rsp_valid_q <= (state_q == RESP);
`endif
    end
  end

  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed ops push expected responses/writes, a negedge monitor checks them.
module tb_mem_access_unit;
  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;
  int   rd_cnt;

  typedef struct { logic [31:0] rdata; logic err; int cyc; } rsp_t;
  typedef struct { logic [7:0] addr; logic [31:0] data; } wr_t;
  rsp_t rq[$];
  wr_t  wq[$];

  logic [31:0] mem [256];

  mem_access_unit_if #(.AW(8)) bus ();
  mem_access_unit #(.AW(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
  assign bus.mem_rdata = bus.mem_read ? mem[bus.mem_addr] : 32'hDEAD_DEAD;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin
    rsp_t e;
    wr_t  w;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.mem_read || bus.mem_write)
          chk("strobe_excl", {31'b0, bus.mem_read & bus.mem_write}, 32'h0);
        if (bus.mem_read) rd_cnt++;
        if (bus.mem_write) begin
          if (wq.size() == 0) chk("unexpected_write", {24'h0, bus.mem_addr}, 32'hFFFF_FFFF);
          else begin
            w = wq.pop_front();
            chk("wr_addr", {24'h0, bus.mem_addr}, {24'h0, w.addr});
            chk("wr_data", bus.mem_wdata, w.data);
          end
        end
        if (bus.rsp_valid) begin
          if (rq.size() == 0) chk("unexpected_rsp", bus.rsp_rdata, 32'hFFFF_FFFF);
          else begin
            e = rq.pop_front();
            chk("rsp_rdata", bus.rsp_rdata, e.rdata);
            chk("rsp_err", {31'b0, bus.misalign_err}, {31'b0, e.err});
            chk("rsp_cycle", cyc, e.cyc);
          end
        end
      end
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_req_ready"}, {31'b0, bus.req_ready}, 32'h1);
    chk({tag, "_rsp_valid"}, {31'b0, bus.rsp_valid}, 32'h0);
    chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'h0);
    chk({tag, "_misalign"}, {31'b0, bus.misalign_err}, 32'h0);
    chk({tag, "_mem_write"}, {31'b0, bus.mem_write}, 32'h0);
    chk({tag, "_mem_read"}, {31'b0, bus.mem_read}, 32'h0);
    chk({tag, "_mem_addr"}, {24'h0, bus.mem_addr}, 32'h0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge with req_valid still high.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                       input int lat, input bit push);
    int n;
    bus.req_we = we; bus.req_size = sz; bus.req_unsigned = uns;
    bus.req_addr = addr; bus.req_wdata = wd; bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    if (!bus.req_ready) begin
      chk("accept_timeout", 32'h0, 32'h1);
      bus.req_valid = 1'b0;
      return;
    end
    if (push) rq.push_back('{exp_rd, exp_err, cyc + 1 + lat});
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rq.size() != 0 || wq.size() != 0) && n < 40) begin @(negedge clk); n++; end
    if (rq.size() != 0 || wq.size() != 0) begin
      chk("drain_timeout", rq.size() + wq.size(), 32'h0);
      rq.delete(); wq.delete();
    end
    @(negedge clk);
  endtask

  task automatic op(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                    input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err, input int lat);
    issue(we, sz, uns, addr, wd, exp_rd, exp_err, lat, 1'b1);
    bus.req_valid = 1'b0;
    drain();
  endtask

  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10;

  initial begin
    int rd0;
    total = 0; bad = 0; cyc = 0; rd_cnt = 0;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = W; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Word stores (also preload for later tests)
    wq.push_back('{8'h04, 32'h1234_5678}); op(1, W, 0, 32'h10, 32'h1234_5678, 32'h0, 0, 2);
    wq.push_back('{8'h03, 32'hCAFE_BABE}); op(1, W, 0, 32'h0C, 32'hCAFE_BABE, 32'h0, 0, 2);
    wq.push_back('{8'h40, 32'h0BAD_F00D}); op(1, W, 0, 32'h100, 32'h0BAD_F00D, 32'h0, 0, 2);
    wq.push_back('{8'h08, 32'hDEAD_BEEF}); op(1, W, 0, 32'h20, 32'hDEAD_BEEF, 32'h0, 0, 2);

    // Loads with lane select and extension
    op(0, W, 0, 32'h10, 32'h0, 32'h1234_5678, 0, 2);
    op(0, B, 0, 32'h13, 32'h0, 32'h0000_0012, 0, 2);
    op(0, H, 0, 32'h12, 32'h0, 32'h0000_1234, 0, 2);

    // Byte store RMW: only bits [7:0] of wdata land in lane 1
    wq.push_back('{8'h04, 32'h1234_AB78}); op(1, B, 0, 32'h11, 32'h7777_77AB, 32'h0, 0, 3);
    op(0, W, 0, 32'h10, 32'h0, 32'h1234_AB78, 0, 2);
    op(0, B, 0, 32'h11, 32'h0, 32'hFFFF_FFAB, 0, 2);
    op(0, B, 1, 32'h11, 32'h0, 32'h0000_00AB, 0, 2);

    // Half store into upper lane of 0xCAFEBABE
    rd0 = rd_cnt;
    wq.push_back('{8'h03, 32'h8001_BABE}); op(1, H, 0, 32'h0E, 32'h5555_8001, 32'h0, 0, 3);
    chk("sh_read_cycles", rd_cnt - rd0, 32'h1);
    op(0, H, 0, 32'h0E, 32'h0, 32'hFFFF_8001, 0, 2);
    op(0, H, 1, 32'h0C, 32'h0, 32'h0000_BABE, 0, 2);
    op(0, B, 0, 32'h0C, 32'h0, 32'hFFFF_FFBE, 0, 2);

    // Address wraps modulo 1 KiB
    op(0, W, 0, 32'h410, 32'h0, 32'h1234_AB78, 0, 2);

    // Misaligned word load
    rd0 = rd_cnt;
`ifdef MISALIGN_TRAP_EN
    op(0, W, 0, 32'h102, 32'h0, 32'h0, 1, 1);
    chk("misalign_reads", rd_cnt - rd0, 32'h0);
`else
    op(0, W, 0, 32'h102, 32'h0, 32'h0BAD_F00D, 0, 2);
    chk("misalign_reads", rd_cnt - rd0, 32'h1);
`endif

    // Back-to-back loads with req_valid held high
    issue(0, W, 0, 32'h10, 32'h0, 32'h1234_AB78, 0, 2, 1'b1);
    chk("b2b_busy0", {31'b0, bus.req_ready}, 32'h0);
    issue(0, W, 0, 32'h0C, 32'h0, 32'h8001_BABE, 0, 2, 1'b1);
    chk("b2b_busy1", {31'b0, bus.req_ready}, 32'h0);
    issue(0, B, 1, 32'h23, 32'h0, 32'h0000_00DE, 0, 2, 1'b1);
    bus.req_valid = 1'b0;
    drain();

    // Reset while the sub-word store is in its read cycle
    issue(1, B, 0, 32'h20, 32'h0000_0055, 32'h0, 0, 3, 1'b0);
    bus.req_valid = 1'b0;
    for (int n = 0; n < 10 && !bus.mem_read; n++) @(negedge clk);
    chk("rmw_read_seen", {31'b0, bus.mem_read}, 32'h1);
    #1 rst_n = 1'b0;
    #1 chk_reset("async_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mem_unchanged", mem[8], 32'hDEAD_BEEF);
    op(0, W, 0, 32'h20, 32'h0, 32'hDEAD_BEEF, 0, 2);

    chk("rsp_queue_empty", rq.size(), 32'h0);
    chk("wr_queue_empty", wq.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
